// File: rtl/d_pop_arbiter.sv
// Round-robin popper for two read-latency-1 FIFOs feeding one registered valid/ready output.
// Optional macro POP_COUNTERS_EN builds saturating per-lane delivered-word counters.
module d_pop_arbiter #(
    parameter int data_width = 6,
    parameter int cnt_width  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [data_width-1:0] data_out_D0,
    input  logic [data_width-1:0] data_out_D1,
    input  logic                  empty_fifo_D0,
    input  logic                  empty_fifo_D1,
    input  logic                  ready_in,
    output logic                  D0_pop,
    output logic                  D1_pop,
    output logic [data_width-1:0] data_out,
    output logic                  valid_out,
    output logic                  lane_out,
    output logic [cnt_width-1:0]  cnt_D0,
    output logic [cnt_width-1:0]  cnt_D1
);

    typedef enum logic [1:0] {IDLE, POP, CAPT} state_t;

    state_t                state_q, state_d;
    logic                  d0_pop_q, d0_pop_d;
    logic                  d1_pop_q, d1_pop_d;
    logic                  valid_q, valid_d;
    logic                  lane_q, lane_d;
    logic                  last_lane_q, last_lane_d;
    logic                  sel_q, sel_d;
    logic [data_width-1:0] data_q, data_d;
    logic                  pick;
    logic                  out_free;

    // The output slot counts as free when it is empty or being accepted this edge.
    assign out_free = !valid_q || ready_in;

    always_comb begin
        state_d     = state_q;
        d0_pop_d    = d0_pop_q;
        d1_pop_d    = d1_pop_q;
        valid_d     = valid_q;
        lane_d      = lane_q;
        last_lane_d = last_lane_q;
        sel_d       = sel_q;
        data_d      = data_q;
        pick        = 1'b0;

        if (valid_q && ready_in) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if ((!empty_fifo_D0 || !empty_fifo_D1) && out_free) begin
                    if (!empty_fifo_D0 && !empty_fifo_D1) begin
                        pick = ~last_lane_q;
                    end else begin
                        pick = empty_fifo_D0;
                    end
                    d0_pop_d    = ~pick;
                    d1_pop_d    = pick;
                    last_lane_d = pick;
                    sel_d       = pick;
                    state_d     = POP;
                end
            end
            POP: begin
                d0_pop_d = 1'b0;
                d1_pop_d = 1'b0;
                state_d  = CAPT;
            end
            CAPT: begin
                // FIFO read data stays put while we wait here, so the word is taken once.
                if (out_free) begin
                    data_d  = sel_q ? data_out_D1 : data_out_D0;
                    lane_d  = sel_q;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            d0_pop_q    <= 1'b0;
            d1_pop_q    <= 1'b0;
            valid_q     <= 1'b0;
            lane_q      <= 1'b0;
            last_lane_q <= 1'b1;
            sel_q       <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            d0_pop_q    <= d0_pop_d;
            d1_pop_q    <= d1_pop_d;
            valid_q     <= valid_d;
            lane_q      <= lane_d;
            last_lane_q <= last_lane_d;
            sel_q       <= sel_d;
            data_q      <= data_d;
        end
    end

    assign D0_pop    = d0_pop_q;
    assign D1_pop    = d1_pop_q;
    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign lane_out  = lane_q;

`ifdef POP_COUNTERS_EN
    logic                 capture;
    logic [cnt_width-1:0] cnt_d0_q, cnt_d0_d;
    logic [cnt_width-1:0] cnt_d1_q, cnt_d1_d;

    assign capture = (state_q == CAPT) && out_free;

    // Counters stick at all-ones instead of wrapping.
    always_comb begin
        cnt_d0_d = cnt_d0_q;
        cnt_d1_d = cnt_d1_q;
        if (capture && !sel_q && (cnt_d0_q != '1)) begin
            cnt_d0_d = cnt_d0_q + cnt_width'(1);
        end
        if (capture && sel_q && (cnt_d1_q != '1)) begin
            cnt_d1_d = cnt_d1_q + cnt_width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_d0_q <= '0;
            cnt_d1_q <= '0;
        end else begin
            cnt_d0_q <= cnt_d0_d;
            cnt_d1_q <= cnt_d1_d;
        end
    end

    assign cnt_D0 = cnt_d0_q;
    assign cnt_D1 = cnt_d1_q;
`else
    assign cnt_D0 = '0;
    assign cnt_D1 = '0;
`endif

endmodule

// File: tb/tb_d_pop_arbiter.sv
// Bench for d_pop_arbiter: queue-based FIFO model, per-lane scoreboard and round-robin lane model.
// Honours POP_COUNTERS_EN the same way as the design.
module tb_d_pop_arbiter;

    localparam int DW = 6;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] data_out_D0, data_out_D1;
    logic          empty_fifo_D0, empty_fifo_D1;
    logic          ready_in;
    logic          D0_pop, D1_pop;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          lane_out;
    logic [CW-1:0] cnt_D0, cnt_D1;

    d_pop_arbiter #(.data_width(DW), .cnt_width(CW)) dut (
        .clk(clk), .reset(reset),
        .data_out_D0(data_out_D0), .data_out_D1(data_out_D1),
        .empty_fifo_D0(empty_fifo_D0), .empty_fifo_D1(empty_fifo_D1),
        .ready_in(ready_in),
        .D0_pop(D0_pop), .D1_pop(D1_pop),
        .data_out(data_out), .valid_out(valid_out), .lane_out(lane_out),
        .cnt_D0(cnt_D0), .cnt_D1(cnt_D1)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            deliv0 = 0, deliv1 = 0;
    int            npop0 = 0, npop1 = 0;
    int            last_pop_cyc = 0, pop_gap = 0;
    bit            model_last = 1'b1;
    bit            blocked_prev = 1'b0, emp0_prev = 1'b1, emp1_prev = 1'b1, rst_prev = 1'b0;
    logic [DW-1:0] fq0[$], fq1[$], exp0[$], exp1[$];
    logic [6:0]    log_q[$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int exp_cnt(input int n);
`ifdef POP_COUNTERS_EN
        return (n > 255) ? 255 : n;
`else
        return 0;
`endif
    endfunction

    task automatic push(input bit lane, input logic [DW-1:0] w);
        if (lane) begin
            fq1.push_back(w);
            exp1.push_back(w);
        end else begin
            fq0.push_back(w);
            exp0.push_back(w);
        end
        empty_fifo_D0 = (fq0.size() == 0);
        empty_fifo_D1 = (fq1.size() == 0);
    endtask

    // One clock: observe at the falling edge, then let the FIFO model react to the rising edge.
    task automatic applyStimulus(input logic rdy);
        logic          p0, p1, exp_lane;
        logic [DW-1:0] w;
        bit            rst_now;
        @(negedge clk);
        p0 = D0_pop;
        p1 = D1_pop;
        rst_now = !reset;
        checkOutput("pop_exclusive", p0 & p1, 0);
`ifndef POP_COUNTERS_EN
        checkOutput("cnt_disabled", {cnt_D1, cnt_D0}, 0);
`endif
        if (p0 || p1) begin
            checkOutput("pop_issued_in_reset", rst_prev, 1);
            checkOutput("pop_while_blocked", blocked_prev, 0);
            checkOutput("pop_from_empty", p1 ? emp1_prev : emp0_prev, 0);
            exp_lane = (!emp0_prev && !emp1_prev) ? ~model_last : emp0_prev;
            checkOutput("pop_lane", p1, exp_lane);
            model_last = exp_lane;
            if (p1) npop1++; else npop0++;
            pop_gap = cyc - last_pop_cyc;
            last_pop_cyc = cyc;
        end
        if (valid_out && ready_in && reset) begin
            log_q.push_back({lane_out, data_out});
            if (lane_out == 1'b0) begin
                checkOutput("d0_word_expected", exp0.size() > 0, 1);
                if (exp0.size() > 0) begin
                    w = exp0.pop_front();
                    checkOutput("d0_word", data_out, w);
                end
                deliv0++;
            end else begin
                checkOutput("d1_word_expected", exp1.size() > 0, 1);
                if (exp1.size() > 0) begin
                    w = exp1.pop_front();
                    checkOutput("d1_word", data_out, w);
                end
                deliv1++;
            end
        end
        blocked_prev = valid_out && !ready_in;
        emp0_prev    = empty_fifo_D0;
        emp1_prev    = empty_fifo_D1;
        rst_prev     = reset;
        if (rst_now) begin
            model_last = 1'b1;
            deliv0 = 0;
            deliv1 = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (p0) begin
            checkOutput("fifo0_underflow", fq0.size() > 0, 1);
            if (fq0.size() > 0) data_out_D0 = fq0.pop_front();
        end
        if (p1) begin
            checkOutput("fifo1_underflow", fq1.size() > 0, 1);
            if (fq1.size() > 0) data_out_D1 = fq1.pop_front();
        end
        // Anything popped but not yet delivered is lost across a reset.
        if (rst_now) begin
            exp0 = fq0;
            exp1 = fq1;
        end
        empty_fifo_D0 = (fq0.size() == 0);
        empty_fifo_D1 = (fq1.size() == 0);
        ready_in = rdy;
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        reset = 1'b1;
    endtask

    initial begin
        int held;
        logic [6:0] order [4];
        order = '{7'h21, 7'h71, 7'h22, 7'h72};
        reset = 1'b0;
        ready_in = 1'b1;
        data_out_D0 = '0;
        data_out_D1 = '0;
        empty_fifo_D0 = 1'b1;
        empty_fifo_D1 = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] reset state");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1);
        checkOutput("rst_valid", valid_out, 0);
        checkOutput("rst_pops", {D1_pop, D0_pop}, 0);
        checkOutput("rst_data", data_out, 0);
        checkOutput("rst_lane", lane_out, 0);
        checkOutput("rst_cnt", {cnt_D1, cnt_D0}, 0);
        reset = 1'b1;

        $display("[TB] single lane D0, latency and spacing");
        push(1'b0, 6'h13);
        push(1'b0, 6'h14);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkOutput("lat_not_yet", valid_out, 0);
        applyStimulus(1'b1);
        checkOutput("lat_valid", valid_out, 1);
        checkOutput("lat_data", data_out, 6'h13);
        checkOutput("lat_lane", lane_out, 0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1);
        checkOutput("d0only_deliv", deliv0, 2);
        checkOutput("d0only_pop_gap", pop_gap, 3);
        checkOutput("d0only_no_d1_pop", npop1, 0);
        checkOutput("d0only_cnt", cnt_D0, exp_cnt(2));

        $display("[TB] both lanes alternate");
        reset_pulse();
        log_q.delete();
        push(1'b0, 6'h21); push(1'b0, 6'h22);
        push(1'b1, 6'h31); push(1'b1, 6'h32);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1);
        checkOutput("alt_count", log_q.size(), 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) checkOutput("alt_order", log_q[i], order[i]);

        $display("[TB] backpressure hold");
        applyStimulus(1'b0);
        push(1'b1, 6'h24);
        push(1'b1, 6'h25);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0);
        checkOutput("hold_valid", valid_out, 1);
        checkOutput("hold_data", data_out, 6'h24);
        held = npop1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0);
            checkOutput("hold_stable", {valid_out, lane_out, data_out}, {2'b11, 6'h24});
        end
        checkOutput("hold_no_pop", npop1, held);
        applyStimulus(1'b1);
        checkOutput("hold_still", valid_out, 1);
        applyStimulus(1'b1);
        checkOutput("hold_release", valid_out, 0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1);
        checkOutput("hold_deliv", deliv1, 4);

        $display("[TB] toggling ready");
        reset_pulse();
        for (int i = 0; i < 3; i++) begin
            push(1'b0, 6'(8 + i));
            push(1'b1, 6'(40 + i));
        end
        for (int i = 0; i < 40; i++) applyStimulus(1'(i % 2));
        for (int i = 0; i < 6; i++) applyStimulus(1'b1);
        checkOutput("tog_deliv", {8'(deliv1), 8'(deliv0)}, {8'd3, 8'd3});
        checkOutput("tog_left", exp0.size() + exp1.size(), 0);
        checkOutput("tog_cnt", cnt_D1, exp_cnt(3));

        $display("[TB] reset while capturing");
        push(1'b0, 6'h10);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        reset = 1'b0;
        applyStimulus(1'b1);
        checkOutput("midrst_valid", valid_out, 0);
        checkOutput("midrst_pops", {D1_pop, D0_pop}, 0);
        checkOutput("midrst_cnt", {cnt_D1, cnt_D0}, 0);
        checkOutput("midrst_fifo0", fq0.size(), 0);
        push(1'b1, 6'h2a);
        reset = 1'b1;
        applyStimulus(1'b1);
        checkOutput("midrst_d1_pop", {D1_pop, D0_pop}, 2'b10);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1);
        checkOutput("midrst_deliv", {8'(deliv1), 8'(deliv0)}, {8'd1, 8'd0});

        $display("[TB] randomized traffic");
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0 && fq0.size() < 4) push(1'b0, 6'($urandom));
            if ($urandom_range(0, 3) == 0 && fq1.size() < 4) push(1'b1, 6'($urandom));
            applyStimulus($urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 200 && (exp0.size() > 0 || exp1.size() > 0 || valid_out); i++) applyStimulus(1'b1);
        checkOutput("rand_drained", exp0.size() + exp1.size(), 0);
        checkOutput("rand_cnt_d0", cnt_D0, exp_cnt(deliv0));
        checkOutput("rand_cnt_d1", cnt_D1, exp_cnt(deliv1));

        $display("[TB] counter saturation");
        reset_pulse();
        for (int i = 0; i < 260; i++) push(1'b0, 6'($urandom));
        for (int i = 0; i < 3000 && (exp0.size() > 0 || valid_out); i++) applyStimulus($urandom_range(0, 4) != 0);
        checkOutput("sat_drained", exp0.size(), 0);
        checkOutput("sat_deliv", deliv0, 260);
        checkOutput("sat_cnt_d0", cnt_D0, exp_cnt(260));
        checkOutput("sat_cnt_d1", cnt_D1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/d_pop_arbiter.md
D_POP_ARBITER -- requirements
Module: d_pop_arbiter

Interface
REQ-001 Parameter: data_width, 6, width of each word read from the D0/D1 FIFOs.
REQ-002 Parameter: cnt_width, 8, width of each per-lane word counter.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset (0 = reset, 1 = run).
REQ-005 Port: data_out_D0  input  data_width  D0 FIFO read data; valid in the cycle after a D0_pop cycle.
REQ-006 Port: data_out_D1  input  data_width  D1 FIFO read data; same timing as data_out_D0.
REQ-007 Port: empty_fifo_D0, empty_fifo_D1  input  1 each  FIFO empty flags.
REQ-008 Port: ready_in  input  1  downstream accepts the word in the output register this cycle.
REQ-009 Port: D0_pop, D1_pop  output  1 each  registered one-cycle FIFO read strobes.
REQ-010 Port: data_out  output  data_width  output word register.
REQ-011 Port: valid_out  output  1  data_out holds an unaccepted word.
REQ-012 Port: lane_out  output  1  source of data_out (0 = D0, 1 = D1).
REQ-013 Port: cnt_D0, cnt_D1  output  cnt_width each  words delivered per lane.

Function
REQ-014 FSM states: IDLE, POP, CAPT; a lane is popped only from IDLE.
REQ-015 IDLE: if a lane is non-empty and the output is free or freeing (!valid_out || ready_in), the FSM registers pop=1 for the selected lane and moves to POP; otherwise it stays in IDLE.
REQ-016 Selection: if exactly one lane is non-empty, that lane is selected; if both are, the lane opposite last_lane is selected; last_lane updates when the pop is issued.
REQ-017 POP: the pop strobe is high for exactly this one cycle; the FSM clears it and moves to CAPT.
REQ-018 CAPT: if !valid_out || ready_in, the FSM loads data_out from the popped lane, sets lane_out, sets valid_out=1, increments that lane's counter, and returns to IDLE; otherwise it stays in CAPT.
REQ-019 FIFO read data is stable while the FSM waits in CAPT, so no word is lost or duplicated.
REQ-020 Output handshake: a word transfers at an edge where valid_out && ready_in. valid_out drops at that edge unless the same edge captures a new word.
REQ-021 D0_pop and D1_pop are never high in the same cycle, and never high when the corresponding empty flag was 1 at the issuing edge.
REQ-022 Throughput: at most one word per 3 cycles; latency from the pop-issuing edge to valid_out=1 is 2 edges when the output is free.
REQ-023 Counters increment by 1 per captured word and saturate at 2^cnt_width-1 (no wrap).
REQ-024 Both lanes empty: the block stays in IDLE with no pops; any pending valid_out is held until accepted.

Reset
REQ-025 While reset=0 at an edge: state=IDLE; D0_pop=D1_pop=0; data_out=0; valid_out=0; lane_out=0; last_lane=1, so D0 wins the first tie; cnt_D0=cnt_D1=0.
REQ-026 Reset asserted mid-operation (POP or CAPT): the in-flight word is discarded, and the pop strobe is 0 from the next cycle.
REQ-027 After reset is released, the first pop may issue at the first edge with reset=1.

Configuration
REQ-028 Macro POP_COUNTERS_EN defined: cnt_D0/cnt_D1 behave per REQ-023.
REQ-029 Macro POP_COUNTERS_EN undefined: the counters are not built, and cnt_D0/cnt_D1 are constant 0; all other behaviour is identical.

Verification
REQ-030 Only D0 holds 2 words (0x13, 0x14), ready_in=1 -> D0_pop pulses 3 cycles apart; data_out=0x13 then 0x14, lane_out=0; cnt_D0=2; D1_pop never high.
REQ-031 D0 and D1 each hold 2 words (D0: 0x21,0x22; D1: 0x31,0x32), ready_in=1, after reset -> output order 0x21(0), 0x31(1), 0x22(0), 0x32(1).
REQ-032 D1 holds 0x24, ready_in=0 for 10 cycles -> valid_out=1, data_out=0x24 held stable, no second pop while held; when ready_in=1, valid_out drops at the next edge.
REQ-033 Both lanes hold 3 words, ready_in toggles every cycle -> no pop issued while the output is blocked; all 6 words delivered exactly once in order per lane; D0_pop&D1_pop never both 1.
REQ-034 reset=0 asserted in CAPT with D0 word 0x10 pending -> next cycle valid_out=0, counters=0, state IDLE; after release with D1 non-empty, D1 is popped.
REQ-035 With POP_COUNTERS_EN, 260 D0 words delivered -> cnt_D0=255 (saturated); without the macro, cnt_D0=0 throughout.
